modbus_reg_arbiter: RTL

- Shares one synchronous-read port of the Modbus holding-register DPRAM between three requesters.
  - Requester 0: the response transmitter (register reads for function 03/04 replies).
  - Requester 1: the write executor (function 06/16).
  - Requester 2: the application port.
- Uses round-robin arbitration with a per-requester burst lock, so a multi-register response reads an atomic snapshot.
- Performs a register-range check on every access.
- Sits between the frame-handling blocks and DPRAM port B.

---
 rtl/modbus_reg_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/modbus_reg_arbiter.sv
// Three-way round-robin arbiter in front of the Modbus holding-register DPRAM port B.
// It supports burst locking so that a multi-register reply reads a consistent snapshot, and range-checks every access.
module modbus_reg_arbiter #(
    parameter int A_WIDTH   = 8,
    parameter int D_WIDTH   = 16,
    parameter int REG_COUNT = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [2:0]             req_in,
    input  logic [2:0]             we_in,
    input  logic [2:0]             lock_in,
    input  logic [3*A_WIDTH-1:0]   addr_in,
    input  logic [3*D_WIDTH-1:0]   wdata_in,
    output logic [2:0]             gnt_out,
    output logic [2:0]             rvalid_out,
    output logic [2:0]             err_out,
    output logic [D_WIDTH-1:0]     rdata_out,
    output logic                   ram_en_out,
    output logic                   ram_we_out,
    output logic [A_WIDTH-1:0]     ram_addr_out,
    output logic [D_WIDTH-1:0]     ram_wdata_out,
    input  logic [D_WIDTH-1:0]     ram_rdata_in
);

    // state     | meaning
    // LOCK_FREE | no owner, round-robin arbitration
    // LOCK_R0   | requester 0 owns the port (bus parked on it)
    // LOCK_R1   | requester 1 owns the port
    // LOCK_R2   | requester 2 owns the port
    typedef enum logic [1:0] {LOCK_FREE, LOCK_R0, LOCK_R1, LOCK_R2} lock_state_t;

    lock_state_t lock_state, lock_state_nxt;

    logic [1:0]         rr_ptr;
    logic               owner_vld;
    logic [1:0]         owner_id;
    logic [1:0]         scan_0, scan_1, scan_2;
    logic               gnt_any;
    logic [1:0]         gnt_id;
    logic [A_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0] sel_wdata;
    logic               sel_we;
    logic               sel_oob;

    logic               s1_vld;
    logic               s1_rd;
    logic               s1_err;
    logic [1:0]         s1_id;
    logic               s2_rd_ok;

    always_comb begin
        owner_vld = 1'b1;
        owner_id  = 2'd0;
        case (lock_state)
            LOCK_R0: owner_id = 2'd0;
            LOCK_R1: owner_id = 2'd1;
            LOCK_R2: owner_id = 2'd2;
            default: owner_vld = 1'b0;
        endcase
    end

    always_comb begin
        scan_0 = 2'd0;
        scan_1 = 2'd1;
        scan_2 = 2'd2;
        case (rr_ptr)
            2'd0: begin scan_0 = 2'd1; scan_1 = 2'd2; scan_2 = 2'd0; end
            2'd1: begin scan_0 = 2'd2; scan_1 = 2'd0; scan_2 = 2'd1; end
            default: begin scan_0 = 2'd0; scan_1 = 2'd1; scan_2 = 2'd2; end
        endcase
    end

    // A lock owner parks the port even while it is idle.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 2'd0;
        if (!rst_in) begin
            if (owner_vld) begin
                if (req_in[owner_id]) begin
                    gnt_any = 1'b1;
                    gnt_id  = owner_id;
                end
            end else if (req_in[scan_0]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_0;
            end else if (req_in[scan_1]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_1;
            end else if (req_in[scan_2]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_2;
            end
        end
        gnt_out = gnt_any ? (3'b001 << gnt_id) : 3'b000;
    end

    always_comb begin
        lock_state_nxt = lock_state;
        case (lock_state)
            LOCK_FREE: begin
                if (gnt_any && lock_in[gnt_id]) begin
                    case (gnt_id)
                        2'd0:    lock_state_nxt = LOCK_R0;
                        2'd1:    lock_state_nxt = LOCK_R1;
                        default: lock_state_nxt = LOCK_R2;
                    endcase
                end
            end
            LOCK_R0: if (!lock_in[0]) lock_state_nxt = LOCK_FREE;
            LOCK_R1: if (!lock_in[1]) lock_state_nxt = LOCK_FREE;
            LOCK_R2: if (!lock_in[2]) lock_state_nxt = LOCK_FREE;
            default: lock_state_nxt = LOCK_FREE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lock_state <= LOCK_FREE;
        end else begin
            lock_state <= lock_state_nxt;
        end
    end

    always_comb begin
        case (gnt_id)
            2'd1: begin
                sel_addr  = addr_in[A_WIDTH +: A_WIDTH];
                sel_wdata = wdata_in[D_WIDTH +: D_WIDTH];
                sel_we    = we_in[1];
            end
            2'd2: begin
                sel_addr  = addr_in[2*A_WIDTH +: A_WIDTH];
                sel_wdata = wdata_in[2*D_WIDTH +: D_WIDTH];
                sel_we    = we_in[2];
            end
            default: begin
                sel_addr  = addr_in[0 +: A_WIDTH];
                sel_wdata = wdata_in[0 +: D_WIDTH];
                sel_we    = we_in[0];
            end
        endcase
        sel_oob = (32'(sel_addr) >= 32'(REG_COUNT));
    end

    // Out-of-range accesses are consumed but never reach the RAM; the address and data registers hold their last value.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr        <= 2'd2;
            ram_en_out    <= 1'b0;
            ram_we_out    <= 1'b0;
            ram_addr_out  <= '0;
            ram_wdata_out <= '0;
            s1_vld        <= 1'b0;
            s1_rd         <= 1'b0;
            s1_err        <= 1'b0;
            s1_id         <= 2'd0;
            rvalid_out    <= 3'b000;
            err_out       <= 3'b000;
            s2_rd_ok      <= 1'b0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= gnt_id;
            end
            ram_en_out <= gnt_any && !sel_oob;
            ram_we_out <= gnt_any && !sel_oob && sel_we;
            if (gnt_any && !sel_oob) begin
                ram_addr_out  <= sel_addr;
                ram_wdata_out <= sel_wdata;
            end
            s1_vld     <= gnt_any;
            s1_rd      <= !sel_we;
            s1_err     <= sel_oob;
            s1_id      <= gnt_id;
            rvalid_out <= (s1_vld && s1_rd)  ? (3'b001 << s1_id) : 3'b000;
            err_out    <= (s1_vld && s1_err) ? (3'b001 << s1_id) : 3'b000;
            s2_rd_ok   <= s1_vld && s1_rd && !s1_err;
        end
    end

    assign rdata_out = s2_rd_ok ? ram_rdata_in : '0;

endmodule
